// File: rtl/ic_bvsge_bvshl_witness_checker.sv
// Sweeps every (s,t) pair, queries an external witness generator, and checks the
// returned witness against an exhaustive search for "exists x. (x << s) >=s t".
module ic_bvsge_bvshl_witness_checker #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic           query_valid,
  output logic [W-1:0]   query_s,
  output logic [W-1:0]   query_t,
  input  logic           wit_valid,
  input  logic [W-1:0]   wit_x,
  output logic [2*W:0]   ic_count,
  output logic [2*W:0]   fail_count,
  output logic [W-1:0]   first_fail_s,
  output logic [W-1:0]   first_fail_t
);

  localparam int KW = 2 * W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUERY,
    S_WAIT,
    S_SEARCH,
    S_CHECK,
    S_DONE
  } state_t;

  state_t          state, state_n;
  logic [KW-1:0]   k;
  logic [W-1:0]    xc;
  logic            ic_r;
  logic            wit_ok;
  logic            pass_r;
  logic            fail_ev;

  // Shift amounts at or beyond the word width flush every bit out.
  function automatic logic [W-1:0] shl(input logic [W-1:0] x, input logic [W-1:0] s);
    if (int'(s) >= W) return '0;
    return x << s;
  endfunction

  function automatic logic sat(input logic [W-1:0] x, input logic [W-1:0] s,
                               input logic [W-1:0] t);
    logic signed [W-1:0] lhs;
    logic signed [W-1:0] rhs;
    lhs = shl(x, s);
    rhs = t;
    return lhs >= rhs;
  endfunction

  assign query_s     = k[KW-1:W];
  assign query_t     = k[W-1:0];
  assign query_valid = (state == S_QUERY) || (state == S_WAIT);
  assign busy        = (state != S_IDLE) && (state != S_DONE);
  assign done        = (state == S_DONE);
  assign pass        = pass_r;
  assign fail_ev     = ic_r & ~wit_ok;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (start) state_n = S_QUERY;
      S_QUERY:  state_n = S_WAIT;
      S_WAIT:   if (wit_valid) state_n = S_SEARCH;
      S_SEARCH: if (xc == '1) state_n = S_CHECK;
      S_CHECK:  state_n = (k == '1) ? S_DONE : S_QUERY;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      k            <= '0;
      ic_count     <= '0;
      fail_count   <= '0;
      first_fail_s <= '0;
      first_fail_t <= '0;
      pass_r       <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          if (start) begin
            k            <= '0;
            ic_count     <= '0;
            fail_count   <= '0;
            first_fail_s <= '0;
            first_fail_t <= '0;
            pass_r       <= 1'b0;
          end
        end
        S_CHECK: begin
          if (ic_r) ic_count <= ic_count + 1'b1;
          if (fail_ev) begin
            fail_count <= fail_count + 1'b1;
            if (fail_count == '0) begin
              first_fail_s <= query_s;
              first_fail_t <= query_t;
            end
          end
          if (k == '1) pass_r <= (fail_count == '0) && !fail_ev;
          else         k      <= k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Witness evaluation and exhaustive candidate search
  always_ff @(posedge clk) begin
    case (state)
      S_WAIT: begin
        if (wit_valid) begin
          wit_ok <= sat(wit_x, query_s, query_t);
          xc     <= '0;
          ic_r   <= 1'b0;
        end
      end
      S_SEARCH: begin
        ic_r <= ic_r | sat(xc, query_s, query_t);
        xc   <= xc + 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ic_bvsge_bvshl_witness_checker.sv
// Bench for ic_bvsge_bvshl_witness_checker: W=4 and W=2 instances driven by
// behavioural witness generators, with an arithmetic reference model.
module tb_ic_bvsge_bvshl_witness_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start4, busy4, done4, pass4, qv4, wv4;
  logic [3:0] qs4, qt4, wx4, ffs4, fft4;
  logic [8:0] icc4, fc4;

  logic       start2, busy2, done2, pass2, qv2, wv2;
  logic [1:0] qs2, qt2, wx2, ffs2, fft2;
  logic [4:0] icc2, fc2;

  ic_bvsge_bvshl_witness_checker #(.W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .busy(busy4), .done(done4), .pass(pass4),
    .query_valid(qv4), .query_s(qs4), .query_t(qt4), .wit_valid(wv4), .wit_x(wx4),
    .ic_count(icc4), .fail_count(fc4), .first_fail_s(ffs4), .first_fail_t(fft4));

  ic_bvsge_bvshl_witness_checker #(.W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
    .query_valid(qv2), .query_s(qs2), .query_t(qt2), .wit_valid(wv2), .wit_x(wx2),
    .ic_count(icc2), .fail_count(fc2), .first_fail_s(ffs2), .first_fail_t(fft2));

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference arithmetic on plain integers
  function automatic int sv(input int v, input int w);
    return (v >= (1 << (w - 1))) ? v - (1 << w) : v;
  endfunction

  function automatic int shlv(input int x, input int s, input int w);
    if (s >= w) return 0;
    return (x * (1 << s)) % (1 << w);
  endfunction

  function automatic bit satm(input int x, input int s, input int t, input int w);
    return sv(shlv(x, s, w), w) >= sv(t, w);
  endfunction

  function automatic bit icm(input int s, input int t, input int w);
    for (int x = 0; x < (1 << w); x++)
      if (satm(x, s, t, w)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int best(input int s, input int w);
    int b  = 0;
    int bv = -100000;
    for (int x = 0; x < (1 << w); x++)
      if (sv(shlv(x, s, w), w) > bv) begin
        bv = sv(shlv(x, s, w), w);
        b  = x;
      end
    return b;
  endfunction

  // W=4 generator: mode 0 best witness, 1 always zero, 2 random; random latency
  int         gmode = 0;
  int         gmaxd = 0;
  bit         noise = 1'b0;
  int         gcnt  = 0;
  int         gdly  = 0;
  logic [3:0] grnd  = 4'd0;
  bit         force_wv = 1'b0;
  logic [3:0] gx;

  always @(posedge clk) begin
    gcnt <= qv4 ? gcnt + 1 : 0;
    if (!qv4) begin
      gdly <= int'($urandom_range(gmaxd, 0));
      grnd <= 4'($urandom);
    end
    force_wv <= noise && ($urandom_range(3, 0) == 0);
  end

  always_comb begin
    gx = 4'd0;
    case (gmode)
      0:       gx = 4'(best(int'(qs4), 4));
      1:       gx = 4'd0;
      default: gx = grnd;
    endcase
  end

  assign wv4 = (qv4 && (gcnt >= gdly)) || (force_wv && !qv4);
  assign wx4 = (force_wv && !qv4) ? ~gx : gx;

  assign wv2 = qv2;
  assign wx2 = 2'(best(int'(qs2), 2));

  // Handshake monitor: stability, one consumption per query, witness capture
  int         hs_cnt = 0;
  int         q_cnt  = 0;
  int         mon_err = 0;
  bit         pqv = 1'b0;
  bit         phs = 1'b0;
  logic [3:0] pqs = 4'd0, pqt = 4'd0;
  int         cons_x [256];

  always @(negedge clk) begin
    if (qv4 && !pqv) q_cnt <= q_cnt + 1;
    if ((qv4 && pqv && ((qs4 != pqs) || (qt4 != pqt))) || (qv4 && phs))
      mon_err <= mon_err + 1;
    if (qv4 && pqv && wv4) begin
      hs_cnt <= hs_cnt + 1;
      cons_x[{qs4, qt4}] <= int'(wx4);
    end
    phs <= qv4 && pqv && wv4;
    pqv <= qv4;
    pqs <= qs4;
    pqt <= qt4;
  end

  typedef struct {
    int mode;
    int maxd;
    bit noise;
    bit use_model;
    int ic;
    int fail;
    int pass;
    int ffs;
    int fft;
    int cycles;
  } vec_t;

  vec_t vecs [5];

  task automatic model4(output int eic, output int efail, output int effs, output int efft);
    eic = 0; efail = 0; effs = 0; efft = 0;
    for (int s = 0; s < 16; s++)
      for (int t = 0; t < 16; t++)
        if (icm(s, t, 4)) begin
          eic++;
          if (!satm(cons_x[s * 16 + t], s, t, 4)) begin
            efail++;
            if (efail == 1) begin effs = s; efft = t; end
          end
        end
  endtask

  task automatic run4(input vec_t v, input string tag);
    int n, got, hs0, q0, e0, eic, efail, epass, effs, efft;
    gmode = v.mode; gmaxd = v.maxd; noise = v.noise;
    hs0 = hs_cnt; q0 = q_cnt; e0 = mon_err;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    chk({tag, "_busy_after_start"}, int'(busy4), 1);
    n = 0; got = 0;
    while (n < 8000) begin
      @(posedge clk); #1;
      n++;
      start4 = (v.noise && busy4 && ($urandom_range(30, 0) == 0));
      if (done4) begin got = 1; break; end
    end
    start4 = 1'b0;
    noise  = 1'b0;
    chk({tag, "_done_seen"}, got, 1);
    if (v.cycles > 0) chk({tag, "_latency"}, n, v.cycles);
    if (v.use_model) begin
      model4(eic, efail, effs, efft);
      epass = (efail == 0);
    end else begin
      eic = v.ic; efail = v.fail; epass = v.pass; effs = v.ffs; efft = v.fft;
    end
    chk({tag, "_busy_at_done"}, int'(busy4), 0);
    chk({tag, "_ic_count"}, int'(icc4), eic);
    chk({tag, "_fail_count"}, int'(fc4), efail);
    chk({tag, "_pass"}, int'(pass4), epass);
    chk({tag, "_first_fail_s"}, int'(ffs4), effs);
    chk({tag, "_first_fail_t"}, int'(fft4), efft);
    chk({tag, "_queries"}, q_cnt - q0, 256);
    chk({tag, "_witnesses"}, hs_cnt - hs0, 256);
    chk({tag, "_handshake_err"}, mon_err - e0, 0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, int'(done4), 0);
    chk({tag, "_ic_hold"}, int'(icc4), eic);
    chk({tag, "_pass_hold"}, int'(pass4), epass);
  endtask

  initial begin
    int n, got;
    vecs[0] = '{0, 0, 1'b0, 1'b0, 161, 0,  1, 0, 0, 4864};
    vecs[1] = '{1, 0, 1'b0, 1'b0, 161, 17, 0, 0, 1, 4864};
    vecs[2] = '{0, 5, 1'b0, 1'b0, 161, 0,  1, 0, 0, -1};
    vecs[3] = '{0, 0, 1'b1, 1'b0, 161, 0,  1, 0, 0, 4864};
    vecs[4] = '{2, 3, 1'b0, 1'b1, 0,   0,  0, 0, 0, -1};

    rst_n = 1'b0; start4 = 1'b0; start2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy4), 0);
    chk("rst_done", int'(done4), 0);
    chk("rst_pass", int'(pass4), 0);
    chk("rst_qv", int'(qv4), 0);
    chk("rst_query", int'({qs4, qt4}), 0);
    chk("rst_counts", int'({icc4, fc4, ffs4, fft4}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) run4(vecs[i], $sformatf("vec%0d", i));

    // Reset during SEARCH of pair k=37 (s=2,t=5)
    gmode = 0; gmaxd = 0;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    got = 0; n = 0;
    while (n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (qs4 == 4'd2 && qt4 == 4'd5 && !qv4 && busy4) begin got = 1; break; end
    end
    chk("k37_reached", got, 1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_busy", int'(busy4), 0);
    chk("abort_done", int'(done4), 0);
    chk("abort_qv", int'(qv4), 0);
    chk("abort_query", int'({qs4, qt4}), 0);
    chk("abort_counts", int'({icc4, fc4, ffs4, fft4, pass4}), 0);
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (done4 || busy4) got = 1;
    end
    chk("abort_quiet", got, 0);
    run4(vecs[0], "after_abort");

    // W=2 instance
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    n = 0; got = 0;
    while (n < 500) begin
      @(posedge clk); #1;
      n++;
      if (done2) begin got = 1; break; end
    end
    chk("w2_done_seen", got, 1);
    chk("w2_latency", n, 112);
    chk("w2_ic_count", int'(icc2), 13);
    chk("w2_fail_count", int'(fc2), 0);
    chk("w2_pass", int'(pass2), 1);
    // start coinciding with done must be ignored
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    chk("w2_start_at_done", int'(busy2), 0);
    chk("w2_hold_ic", int'(icc2), 13);
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    chk("w2_start_idle", int'(busy2), 1);
    n = 0; got = 0;
    while (n < 500) begin
      @(posedge clk); #1;
      n++;
      if (done2) begin got = 1; break; end
    end
    chk("w2_second_done", got, 1);
    chk("w2_second_ic", int'(icc2), 13);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
